snake_move: RTL

- Upstream neighbour of the game-state FSM: owns the snake body and advances it one grid cell per step tick while the game is in PLAY.
- Produces the hitwall/hitbody flags consumed by the FSM, plus an eat pulse for the score/food logic.
- Provides a registered cell-occupancy query for the VGA renderer.
- Consumes the FSM's status and restart outputs, and the four debounced direction key pulses.

---
 rtl/snake_move.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/snake_move.sv
// snake_move: owns the snake body, advances it one cell per step tick while
// the game is in PLAY, flags wall/self collisions, pulses eat on entering the
// apple cell, and answers a registered cell-occupancy query for the renderer.
//
// Ports:
//   clk, rst (async, active-low)      clock and reset
//   status[1:0], restart              game-state FSM status and restart level
//   key1..key4                        up/down/left/right one-cycle requests
//   apple_x/apple_y                   apple cell
//   cell_x/cell_y                     renderer query cell
//   head_x/head_y, body_len           current head and length
//   hitwall, hitbody                  sticky collision flags
//   eat                               one-cycle pulse when the head eats
//   is_head, is_body                  query result, one cycle after cell_x/y
//
// Optional feature macro: WRAP_WALL_EN -- edges wrap to the opposite side and
// hitwall is never set.
module snake_move #(
    parameter int unsigned GRID_W   = 40,
    parameter int unsigned GRID_H   = 30,
    parameter int unsigned MAX_LEN  = 16,
    parameter int unsigned INIT_LEN = 3,
    parameter int unsigned STEP_CYC = 12_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] status,
    input  logic       restart,
    input  logic       key1,
    input  logic       key2,
    input  logic       key3,
    input  logic       key4,
    input  logic [5:0] apple_x,
    input  logic [4:0] apple_y,
    input  logic [5:0] cell_x,
    input  logic [4:0] cell_y,
    output logic [5:0] head_x,
    output logic [4:0] head_y,
    output logic [4:0] body_len,
    output logic       hitwall,
    output logic       hitbody,
    output logic       eat,
    output logic       is_head,
    output logic       is_body
);

    localparam int unsigned XW = 6;
    localparam int unsigned YW = 5;
    localparam int unsigned LW = 5;
    localparam int unsigned CW = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STEP_CYC - 1);
    localparam logic [1:0] ST_RESTART = 2'b00;
    localparam logic [1:0] ST_PLAY    = 2'b10;

    // Encoding chosen so that a direction's reverse differs only in bit 0.
    typedef enum logic [1:0] {UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3} dir_t;

    logic [XW-1:0] seg_x [MAX_LEN];
    logic [YW-1:0] seg_y [MAX_LEN];
    dir_t          dir;
    dir_t          pending_dir;
    logic [CW-1:0] step_cnt;

    dir_t          key_dir_c;
    logic          key_valid_c;
    logic          key_rev_c;
    logic          step_c;
    logic [XW-1:0] nx_c;
    logic [YW-1:0] ny_c;
    logic          edge_c;
    logic          wall_c;
    logic          apple_c;
    logic          grow_c;
    logic          body_c;
    logic [LW-1:0] hit_lim_c;
    logic          q_head_c;
    logic          q_body_c;

    assign head_x = seg_x[0];
    assign head_y = seg_y[0];

    // Highest-priority key; a reverse of the direction in force at this edge is ignored.
    always_comb begin
        key_valid_c = 1'b1;
        key_dir_c   = UP;
        if (key1)      key_dir_c = UP;
        else if (key2) key_dir_c = DOWN;
        else if (key3) key_dir_c = LEFT;
        else if (key4) key_dir_c = RIGHT;
        else           key_valid_c = 1'b0;
        key_rev_c = ((2'(key_dir_c) ^ 2'(step_c ? pending_dir : dir)) == 2'b01);
    end

    assign step_c = (status == ST_PLAY) && (step_cnt == CNT_LAST) && !hitwall && !hitbody;

    // Next head; the edge test precedes the add, the wrapped value is used only with wrap enabled.
    always_comb begin
        nx_c   = seg_x[0];
        ny_c   = seg_y[0];
        edge_c = 1'b0;
        case (pending_dir)
            UP:    if (seg_y[0] == '0) begin edge_c = 1'b1; ny_c = YW'(GRID_H - 1); end
                   else ny_c = seg_y[0] - YW'(1);
            DOWN:  if (seg_y[0] == YW'(GRID_H - 1)) begin edge_c = 1'b1; ny_c = '0; end
                   else ny_c = seg_y[0] + YW'(1);
            LEFT:  if (seg_x[0] == '0) begin edge_c = 1'b1; nx_c = XW'(GRID_W - 1); end
                   else nx_c = seg_x[0] - XW'(1);
            default: if (seg_x[0] == XW'(GRID_W - 1)) begin edge_c = 1'b1; nx_c = '0; end
                   else nx_c = seg_x[0] + XW'(1);
        endcase
`ifdef WRAP_WALL_EN
        wall_c = 1'b0;
`else
        wall_c = edge_c;
`endif
        apple_c   = (nx_c == apple_x) && (ny_c == apple_y);
        grow_c    = apple_c && (body_len < LW'(MAX_LEN));
        // The tail cell is only free when the snake is not growing this step.
        hit_lim_c = grow_c ? body_len : LW'(body_len - LW'(1));
        body_c    = 1'b0;
        for (int k = 1; k < int'(MAX_LEN); k++) begin
            if (LW'(k) < hit_lim_c && seg_x[k] == nx_c && seg_y[k] == ny_c) body_c = 1'b1;
        end
    end

    // Occupancy of the query cell over live segments only.
    always_comb begin
        q_head_c = (seg_x[0] == cell_x) && (seg_y[0] == cell_y);
        q_body_c = 1'b0;
        for (int k = 1; k < int'(MAX_LEN); k++) begin
            if (LW'(k) < body_len && seg_x[k] == cell_x && seg_y[k] == cell_y) q_body_c = 1'b1;
        end
    end

    // Snake state: restart reloads the initial snake and overrides any step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(MAX_LEN); i++) begin
                seg_x[i] <= (i < int'(INIT_LEN)) ? XW'(GRID_W / 2 - i) : '0;
                seg_y[i] <= YW'(GRID_H / 2);
            end
            dir         <= RIGHT;
            pending_dir <= RIGHT;
            body_len    <= LW'(INIT_LEN);
            step_cnt    <= '0;
            hitwall     <= 1'b0;
            hitbody     <= 1'b0;
            eat         <= 1'b0;
        end else if (restart) begin
            for (int i = 0; i < int'(MAX_LEN); i++) begin
                seg_x[i] <= (i < int'(INIT_LEN)) ? XW'(GRID_W / 2 - i) : '0;
                seg_y[i] <= YW'(GRID_H / 2);
            end
            dir         <= RIGHT;
            pending_dir <= RIGHT;
            body_len    <= LW'(INIT_LEN);
            step_cnt    <= '0;
            hitwall     <= 1'b0;
            hitbody     <= 1'b0;
            eat         <= 1'b0;
        end else begin
            eat <= 1'b0;
            if (status == ST_PLAY) step_cnt <= (step_cnt == CNT_LAST) ? '0 : step_cnt + CW'(1);
            if (status != ST_RESTART && key_valid_c && !key_rev_c) pending_dir <= key_dir_c;
            if (step_c) begin
                dir <= pending_dir;
                if (wall_c) begin
                    hitwall <= 1'b1;
                end else if (body_c) begin
                    hitbody <= 1'b1;
                end else begin
                    for (int i = 1; i < int'(MAX_LEN); i++) begin
                        seg_x[i] <= seg_x[i-1];
                        seg_y[i] <= seg_y[i-1];
                    end
                    seg_x[0] <= nx_c;
                    seg_y[0] <= ny_c;
                    if (apple_c) eat <= 1'b1;
                    if (grow_c)  body_len <= body_len + LW'(1);
                end
            end
        end
    end

    // Registered renderer query; head wins over body.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            is_head <= 1'b0;
            is_body <= 1'b0;
        end else if (restart) begin
            is_head <= 1'b0;
            is_body <= 1'b0;
        end else begin
            is_head <= q_head_c;
            is_body <= !q_head_c && q_body_c;
        end
    end

endmodule
